rr_mux_reg: RTL
===============

Name: rr_mux_reg

Overview:
- Parametrised successor to the combinational 4:1 mux: a CHANNELS-input, N-bit registered multiplexer with round-robin arbitration and valid/ready handshakes on every port.
- Selects one requesting input channel per transfer and registers its data into a single-entry output stage.
- Reports which channel was granted alongside the data.
- Sits between multiple producers (e.g. peripheral request sources) and one shared consumer.

Parameters:
- N, 8, data width per channel in bits.
- CHANNELS, 4, number of input channels; legal range 2..16.
- SEL_W, $clog2(CHANNELS), width of the select/grant index; derived, never overridden.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  CHANNELS  per-channel request; bit k belongs to channel k.
- in_data  input  CHANNELS*N  flattened channel data; channel k occupies bits [k*N +: N].
- in_ready  output  CHANNELS  one-hot (or zero) accept strobe back to the channels.
- out_valid  output  1  output register holds valid data.
- out_ready  input  1  consumer accepts the output this cycle.
- out_data  output  N  registered data of the granted channel.
- out_select  output  SEL_W  index of the channel that produced out_data.

Behaviour:
- Single clock domain. Reset is asynchronous and active-high. On rst assertion, immediately:
  - out_valid=0, out_data=0, out_select=0.
  - Priority pointer ptr=0.
  - in_ready=0 while rst is held.
- load = !out_valid || out_ready. The output register may capture a new word this cycle, including same-cycle drain and refill.
- Grant is combinational:
  - Search in_valid starting at index ptr, wrapping modulo CHANNELS.
  - The first set bit k wins.
  - grant is one-hot at bit k, or zero if no valid.
  - in_ready = grant & {CHANNELS{load}}.
- Transfer on channel k when in_valid[k] && in_ready[k]. On the next edge:
  - out_data ← channel k data.
  - out_select ← k.
  - out_valid ← 1.
  - ptr ← (k+1) mod CHANNELS. Wrap: k=CHANNELS-1 → ptr=0.
- Drain without refill (out_valid && out_ready && no grant): out_valid ← 0. out_data and out_select hold their last value.
- Stall (out_valid && !out_ready): in_ready=0. Output register, out_select and ptr all hold.
- ptr changes only on a transfer. Idle cycles never move it.
- Latency: 1 cycle from input transfer to out_valid. Sustained throughput is 1 word/cycle when out_ready stays high.
- Fairness: with all channels continuously valid, grant order is 0,1,2,…,CHANNELS-1,0,…
- Inputs must hold in_valid/in_data stable until transfer. The block does not check this.
- Reset mid-transfer: the in-flight output word is discarded and no in_ready is issued. After deassertion, arbitration restarts at channel 0.
- No combinational path from out_ready to out_data. The path out_ready→in_ready is permitted.

Optional Feature:
- Macro RR_MUX_FIXED_PRIORITY_EN.
- When defined:
  - ptr is removed.
  - The search always starts at index 0, so the lowest valid index wins: strict priority.
  - All other behaviour is identical.
- When undefined: round-robin as specified above.

Decomposition:
- Package rr_mux_pkg holds:
  - Function sel_width(int channels) returning $clog2 with a minimum of 1.
  - localparam MAX_CHANNELS=16.
- One natural sub-module: rr_pick. It is a purely combinational rotate / find-first-set / unrotate taking in_valid and ptr, returning a one-hot grant and its index.
- rr_mux_reg owns the ptr register, the output register and the handshake.

Test Plan (CHANNELS=4, N=2, in_data channel k = k):
- Reset state: assert rst for 2 cycles mid-stream → out_valid=0, out_data=0, out_select=0, in_ready=4'b0000. After release, first grant with in_valid=4'b1111 is channel 0.
- Single channel: in_valid=4'b0100, out_ready=1 → in_ready=4'b0100. Next cycle out_valid=1, out_data=2, out_select=2.
- Round-robin: in_valid=4'b1111, out_ready=1 for 6 cycles → out_select sequence 0,1,2,3,0,1 with out_data equal to out_select. Checked with ===, as in the mux4 bench.
- Wrap and skip: ptr=3 after granting channel 2, in_valid=4'b0011 → channel 0 granted, then channel 1.
- Backpressure: out_ready=0 with out_valid=1 for 3 cycles → in_ready=0 and out_data/out_select stable. Raising out_ready gives a same-cycle drain and refill with no bubble.
- RR_MUX_FIXED_PRIORITY_EN build: in_valid=4'b1111 for 4 cycles → out_select stays 0 every cycle.

Source files
------------

// File: rtl/rr_mux_pkg.sv
// rr_mux_pkg: shared constants and helpers for the round-robin registered mux.
//   MAX_CHANNELS : largest supported channel count.
//   sel_width()  : width of a channel index, never below one bit.
package rr_mux_pkg;

  localparam int MAX_CHANNELS = 16;

  function automatic int sel_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/rr_mux_reg_if.sv
// rr_mux_reg_if: handshake bundle between CHANNELS producers and one consumer.
//   in_valid   [CHANNELS]    per-channel request, bit k is channel k
//   in_data    [CHANNELS*N]  channel k data at [k*N +: N]
//   in_ready   [CHANNELS]    one-hot (or zero) accept strobe
//   out_valid  [1]           output register holds a word
//   out_ready  [1]           consumer takes the word this cycle
//   out_data   [N]           registered data of the granted channel
//   out_select [SEL_W]       index of the channel that produced out_data
// Modports: master = producer/consumer side, slave = mux side.
interface rr_mux_reg_if
  import rr_mux_pkg::*;
#(
  parameter int N        = 8,
  parameter int CHANNELS = 4
) ();

  localparam int SEL_W = sel_width(CHANNELS);

  logic [CHANNELS-1:0]   in_valid;
  logic [CHANNELS*N-1:0] in_data;
  logic [CHANNELS-1:0]   in_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [N-1:0]          out_data;
  logic [SEL_W-1:0]      out_select;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_select
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_select
  );

endinterface

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker.
// Rotates the request vector right by ptr, finds the lowest set bit, then
// maps that offset back to an absolute channel index.
//   valid [CHANNELS]  requests
//   ptr   [SEL_W]     highest-priority channel this cycle
//   grant [CHANNELS]  one-hot winner, zero when nothing requests
//   idx   [SEL_W]     index of the winner (0 when nothing requests)
module rr_pick
  import rr_mux_pkg::*;
#(
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = sel_width(CHANNELS)
) (
  input  logic [CHANNELS-1:0] valid,
  input  logic [SEL_W-1:0]    ptr,
  output logic [CHANNELS-1:0] grant,
  output logic [SEL_W-1:0]    idx
);

  logic [CHANNELS-1:0] rot;
  logic                hit;
  int                  off;
  int                  abs_idx;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    rot     = '0;
    hit     = 1'b0;
    off     = 0;
    abs_idx = 0;
    grant   = '0;
    idx     = '0;

    // Doubling the vector turns the wrap-around rotate into a plain shift.
    rot = CHANNELS'({valid, valid} >> ptr);

    // Scan downwards so the lowest set bit is the last one to win.
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (rot[i]) begin
        hit = 1'b1;
        off = i;
      end
    end

    abs_idx = int'(ptr) + off;
    if (abs_idx >= CHANNELS) abs_idx = abs_idx - CHANNELS;

    if (hit) begin
      idx   = SEL_W'(abs_idx);
      grant = CHANNELS'(1) << idx;
    end
  end

endmodule

// File: rtl/rr_mux_reg.sv
// rr_mux_reg: CHANNELS-input, N-bit registered multiplexer with round-robin
// arbitration and valid/ready handshakes on every port.
//   clk  rising-edge clock
//   rst  asynchronous, active-high reset
//   bus  rr_mux_reg_if.slave (in_valid/in_data/in_ready,
//        out_valid/out_ready/out_data/out_select)
// Define RR_MUX_FIXED_PRIORITY_EN to drop the rotating pointer and use strict
// priority (lowest requesting index wins); otherwise arbitration is
// round-robin starting after the last granted channel.
module rr_mux_reg
  import rr_mux_pkg::*;
#(
  parameter  int N        = 8,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = sel_width(CHANNELS)
) (
  input logic        clk,
  input logic        rst,
  rr_mux_reg_if.slave bus
);

  if (CHANNELS < 2 || CHANNELS > MAX_CHANNELS) begin : g_bad_channels
    $error("rr_mux_reg: CHANNELS must be in 2..%0d", MAX_CHANNELS);
  end

  logic [CHANNELS-1:0] grant;
  logic [SEL_W-1:0]    gidx;
  logic [SEL_W-1:0]    ptr;
  logic [N-1:0]        pick_data;
  logic                load;
  logic                xfer;

`ifdef RR_MUX_FIXED_PRIORITY_EN
  assign ptr = '0;
`endif

  rr_pick #(.CHANNELS(CHANNELS)) u_pick (
    .valid (bus.in_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gidx)
  );

  // The output register can take a word when empty or being drained now.
  assign load         = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = rst ? '0 : (grant & {CHANNELS{load}});
  assign xfer         = |bus.in_ready;

  always_comb begin
    pick_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (gidx == SEL_W'(k)) pick_data = bus.in_data[k*N +: N];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: data and select are reset too, so the consumer never sees X
      // on out_data/out_select before the first transfer.
      bus.out_valid  <= 1'b0;
      bus.out_data   <= '0;
      bus.out_select <= '0;
    end else if (load) begin
      if (xfer) begin
        bus.out_valid  <= 1'b1;
        bus.out_data   <= pick_data;
        bus.out_select <= gidx;
      end else begin
        // Drain without refill: data and select keep their last value.
        bus.out_valid <= 1'b0;
      end
    end
  end

`ifndef RR_MUX_FIXED_PRIORITY_EN
  // Pointer moves only on a transfer, to the channel after the winner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (xfer) begin
      ptr <= (gidx == SEL_W'(CHANNELS - 1)) ? '0 : gidx + SEL_W'(1);
    end
  end
`endif

endmodule
